// File: rtl/restoring_divider.sv
// Sequential unsigned restoring divider: one quotient bit per clock, start/busy/done handshake.
// Results are held in output registers until the next operation completes.
module restoring_divider #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [W-1:0] dividend,
    input  logic [W-1:0] divisor,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] quotient,
    output logic [W-1:0] remainder,
    output logic         div_by_zero
);

    localparam int unsigned CW = $clog2(W + 1);

    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StCalc = 2'd1;
    localparam logic [1:0] StDone = 2'd2;

    logic [1:0]    state_q, state_d;
    logic [CW-1:0] cnt_q;
    logic [W-1:0]  rem_q;
    logic [W-1:0]  quo_q;
    logic [W-1:0]  div_q;

    logic [W:0]    shifted;
    logic [W:0]    trial;
    logic [W-1:0]  rem_nxt;
    logic [W-1:0]  quo_nxt;
    logic          last_iter;

    // The partial remainder is always below the divisor after each step, so its
    // top bit is zero and only W bits are stored between iterations.
    always_comb begin
        shifted = {rem_q, quo_q[W-1]};
        trial   = shifted - {1'b0, div_q};
        if (!trial[W]) begin
            rem_nxt = trial[W-1:0];
            quo_nxt = {quo_q[W-2:0], 1'b1};
        end else begin
            rem_nxt = shifted[W-1:0];
            quo_nxt = {quo_q[W-2:0], 1'b0};
        end
    end

    assign last_iter = (cnt_q == CW'(W - 1));

    always_comb begin
        state_d = state_q;
        case (state_q)
            StCalc: begin
                if (last_iter) begin
                    state_d = StDone;
                end
            end
            StIdle, StDone: begin
                if (start) begin
                    state_d = (divisor == '0) ? StDone : StCalc;
                end else begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            rem_q       <= '0;
            quo_q       <= '0;
            div_q       <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else begin
            state_q <= state_d;
            busy    <= (state_d == StCalc);
            done    <= (state_d == StDone);
            case (state_q)
                StCalc: begin
                    rem_q <= rem_nxt;
                    quo_q <= quo_nxt;
                    cnt_q <= cnt_q + 1'b1;
                    if (last_iter) begin
                        quotient    <= quo_nxt;
                        remainder   <= rem_nxt;
                        div_by_zero <= 1'b0;
                    end
                end
                StIdle, StDone: begin
                    if (start) begin
                        if (divisor == '0) begin
                            quotient    <= '1;
                            remainder   <= dividend;
                            div_by_zero <= 1'b1;
                        end else begin
                            rem_q <= '0;
                            quo_q <= dividend;
                            div_q <= divisor;
                            cnt_q <= '0;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
